// File: rtl/wts_adsr_pkg.sv
// Shared types and helpers for the wave-table ADSR envelope generator.
// Contents: phase encoding, rate/sustain-level field widths, sustain target helper.
package wts_adsr_pkg;

   localparam int unsigned RATE_W = 8;
   localparam int unsigned SL_W   = 4;
   localparam int unsigned PH_W   = 3;

   typedef enum logic [PH_W-1:0] {
      PH_IDLE    = 3'd0,
      PH_ATTACK  = 3'd1,
      PH_DECAY   = 3'd2,
      PH_SUSTAIN = 3'd3,
      PH_RELEASE = 3'd4
   } adsr_phase_t;

   // Sustain level scaled up to the envelope width (SL occupies the top bits below full scale).
   function automatic int unsigned sustain_target(input logic [SL_W-1:0] sl, input int unsigned env_w);
      return 32'(sl) << (env_w - 5);
   endfunction

endpackage

// File: rtl/wts_adsr_channel.sv
// One ADSR channel: phase, level, rate counter and pending key requests.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   service                    this channel owns the current slot
//   key_on/key_release/key_off request pulses (latched until serviced)
//   reg_ar/dr/sr/rr, reg_sl    rates and sustain level, sampled on service
//   reg_legato                 key_on keeps current level
//   level_nxt_c, phase_nxt_c   post-update level/phase (combinational, for the output mux)
//   idle                       registered: channel is in IDLE
module wts_adsr_channel
   import wts_adsr_pkg::*;
#(
   parameter int unsigned ENV_W = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              service,
   input  logic              key_on,
   input  logic              key_release,
   input  logic              key_off,
   input  logic [RATE_W-1:0] reg_ar,
   input  logic [RATE_W-1:0] reg_dr,
   input  logic [RATE_W-1:0] reg_sr,
   input  logic [RATE_W-1:0] reg_rr,
   input  logic [SL_W-1:0]   reg_sl,
   input  logic              reg_legato,
   output logic [ENV_W-1:0]  level_nxt_c,
   output logic [PH_W-1:0]   phase_nxt_c,
   output logic              idle
);

   localparam int unsigned       ENV_MAX = 1 << (ENV_W - 1);
   localparam logic [ENV_W-1:0]  LVL_MAX = ENV_W'(ENV_MAX);

   adsr_phase_t       phase_q, phase_nxt;
   logic [ENV_W-1:0]  level_q, level_nxt;
   logic [RATE_W-1:0] cnt_q, cnt_nxt;
   logic              p_on_q, p_rel_q, p_off_q;
   logic              p_on_nxt, p_rel_nxt, p_off_nxt;
   logic [RATE_W-1:0] rate;
   logic [RATE_W:0]   cnt_inc;
   logic              step_due;
   logic [ENV_W-1:0]  target;

   assign cnt_inc = {1'b0, cnt_q} + (RATE_W+1)'(1);
   assign target  = ENV_W'(sustain_target(reg_sl, ENV_W));

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         phase_q <= PH_IDLE;
         level_q <= '0;
         cnt_q   <= '0;
         p_on_q  <= 1'b0;
         p_rel_q <= 1'b0;
         p_off_q <= 1'b0;
         idle    <= 1'b1;
      end else begin
         phase_q <= phase_nxt;
         level_q <= level_nxt;
         cnt_q   <= cnt_nxt;
         p_on_q  <= p_on_nxt;
         p_rel_q <= p_rel_nxt;
         p_off_q <= p_off_nxt;
         idle    <= (phase_nxt == PH_IDLE);
      end
   end

   // Event handling and rate stepping
   always_comb begin
      phase_nxt = phase_q;
      level_nxt = level_q;
      cnt_nxt   = cnt_q;
      p_on_nxt  = p_on_q | key_on;
      p_rel_nxt = p_rel_q | key_release;
      p_off_nxt = p_off_q | key_off;
      rate      = '0;
      step_due  = 1'b0;

      if (service) begin
         // Same-cycle pulses are folded into this service, so nothing stays pending.
         p_on_nxt  = 1'b0;
         p_rel_nxt = 1'b0;
         p_off_nxt = 1'b0;

         if (p_off_q | key_off) begin
            phase_nxt = PH_IDLE;
            level_nxt = '0;
            cnt_nxt   = '0;
         end else if (p_on_q | key_on) begin
            cnt_nxt = '0;
            if (reg_ar == '0) begin
               phase_nxt = PH_DECAY;
               level_nxt = LVL_MAX;
            end else begin
               phase_nxt = PH_ATTACK;
               if (!reg_legato) level_nxt = '0;
            end
         end else if ((p_rel_q | key_release) && (phase_q != PH_IDLE)) begin
            phase_nxt = PH_RELEASE;
            cnt_nxt   = '0;
         end else begin
            case (phase_q)
               PH_ATTACK:  rate = reg_ar;
               PH_DECAY:   rate = reg_dr;
               PH_SUSTAIN: rate = reg_sr;
               PH_RELEASE: rate = reg_rr;
               default:    rate = '0;
            endcase

            step_due = (rate != '0) && (cnt_inc >= {1'b0, rate});
            if (rate != '0) cnt_nxt = step_due ? '0 : cnt_inc[RATE_W-1:0];

            case (phase_q)
               PH_ATTACK: begin
                  if (step_due) begin
                     if (level_q >= LVL_MAX - ENV_W'(1)) begin
                        level_nxt = LVL_MAX;
                        phase_nxt = PH_DECAY;
                        cnt_nxt   = '0;
                     end else begin
                        level_nxt = level_q + ENV_W'(1);
                     end
                  end
               end
               PH_DECAY: begin
                  // Reaching the target is checked before any step is taken.
                  if (level_q <= target) begin
                     phase_nxt = PH_SUSTAIN;
                     cnt_nxt   = '0;
                  end else if (rate == '0) begin
                     phase_nxt = PH_SUSTAIN;
                     level_nxt = target;
                     cnt_nxt   = '0;
                  end else if (step_due) begin
                     level_nxt = level_q - ENV_W'(1);
                  end
               end
               PH_SUSTAIN: begin
                  if (step_due && (level_q != '0)) level_nxt = level_q - ENV_W'(1);
               end
               PH_RELEASE: begin
                  if (step_due) begin
                     if (level_q <= ENV_W'(1)) begin
                        level_nxt = '0;
                        phase_nxt = PH_IDLE;
                        cnt_nxt   = '0;
                     end else begin
                        level_nxt = level_q - ENV_W'(1);
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign level_nxt_c = level_nxt;
   assign phase_nxt_c = phase_nxt;

endmodule

// File: rtl/wts_adsr_envelope_generator_nch.sv
// Time-multiplexed N-channel ADSR envelope generator.
// Ports:
//   clk, reset                        clock, synchronous active-high reset
//   active                            slot being serviced; >= CH_NUM is a no-op slot
//   key_on/key_release/key_off        per-channel request pulses
//   reg_ar/dr/sr/rr (8b per ch)       rates
//   reg_sl (4b per ch), reg_legato    sustain level, legato enable
//   envelope, phase                   level/phase of the channel serviced last cycle
//   ch_idle                           per-channel IDLE flag
module wts_adsr_envelope_generator_nch
   import wts_adsr_pkg::*;
#(
   parameter int unsigned CH_NUM = 5,
   parameter int unsigned ENV_W  = 5,
   localparam int unsigned AW    = $clog2(CH_NUM + 1)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [AW-1:0]            active,
   input  logic [CH_NUM-1:0]        key_on,
   input  logic [CH_NUM-1:0]        key_release,
   input  logic [CH_NUM-1:0]        key_off,
   input  logic [CH_NUM*RATE_W-1:0] reg_ar,
   input  logic [CH_NUM*RATE_W-1:0] reg_dr,
   input  logic [CH_NUM*RATE_W-1:0] reg_sr,
   input  logic [CH_NUM*RATE_W-1:0] reg_rr,
   input  logic [CH_NUM*SL_W-1:0]   reg_sl,
   input  logic [CH_NUM-1:0]        reg_legato,
   output logic [ENV_W-1:0]         envelope,
   output logic [PH_W-1:0]          phase,
   output logic [CH_NUM-1:0]        ch_idle
);

   logic [ENV_W-1:0] lvl_nxt [CH_NUM];
   logic [PH_W-1:0]  ph_nxt  [CH_NUM];
   logic [ENV_W-1:0] env_sel;
   logic [PH_W-1:0]  ph_sel;

   // One channel instance per slot
   for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
      wts_adsr_channel #(.ENV_W(ENV_W)) u_ch (
         .clk         (clk),
         .reset       (reset),
         .service     (active == AW'(i)),
         .key_on      (key_on[i]),
         .key_release (key_release[i]),
         .key_off     (key_off[i]),
         .reg_ar      (reg_ar[i*RATE_W +: RATE_W]),
         .reg_dr      (reg_dr[i*RATE_W +: RATE_W]),
         .reg_sr      (reg_sr[i*RATE_W +: RATE_W]),
         .reg_rr      (reg_rr[i*RATE_W +: RATE_W]),
         .reg_sl      (reg_sl[i*SL_W +: SL_W]),
         .reg_legato  (reg_legato[i]),
         .level_nxt_c (lvl_nxt[i]),
         .phase_nxt_c (ph_nxt[i]),
         .idle        (ch_idle[i])
      );
   end

   // Select the serviced channel; no-op slots read as 0 / IDLE
   always_comb begin
      env_sel = '0;
      ph_sel  = PH_IDLE;
      for (int i = 0; i < CH_NUM; i++) begin
         if (active == AW'(i)) begin
            env_sel = lvl_nxt[i];
            ph_sel  = ph_nxt[i];
         end
      end
   end

   // Output register
   always_ff @(posedge clk) begin
      if (reset) begin
         envelope <= '0;
         phase    <= PH_IDLE;
      end else begin
         envelope <= env_sel;
         phase    <= ph_sel;
      end
   end

endmodule
